// File: rtl/spi_rx_fifo_if.sv
// Read-side bus of the serial-link receiver: FIFO status, head data, sticky error flags.
// master = receiver (drives status/data), slave = consumer (drives read/clear).
interface spi_rx_fifo_if;
  localparam int unsigned DATA_W = 9;

  logic              o_Empty;
  logic              o_Full;
  logic              i_Read;
  logic [DATA_W-1:0] o_Data;
  logic              o_Overrun;
  logic              o_Frame_Err;
  logic              i_Clr_Err;

  modport master (
    output o_Empty, o_Full, o_Data, o_Overrun, o_Frame_Err,
    input  i_Read, i_Clr_Err
  );

  modport slave (
    input  o_Empty, o_Full, o_Data, o_Overrun, o_Frame_Err,
    output i_Read, i_Clr_Err
  );
endinterface

// File: rtl/spi_rx_fifo.sv
// Responder for the three-wire strobe/clock/data link: oversamples, deserialises LSB-first
// bytes, tags frame-first bytes and buffers them in a FWFT FIFO. SPI_RX_DIAG_EN adds diag outputs.
module spi_rx_fifo #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  input  logic          i_SPI_Stb,
  input  logic          i_SPI_Clk,
  input  logic          i_SPI_Dio,
  spi_rx_fifo_if.master rx
`ifdef SPI_RX_DIAG_EN
  ,
  output logic [1:0]                    o_Diag_State,
  output logic [2:0]                    o_Diag_Bit_Cnt,
  output logic [7:0]                    o_Diag_Shift,
  output logic [$clog2(FIFO_DEPTH):0]   o_Diag_Count
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  // Line synchronisers and SPI clock edge detect
  logic [SYNC_STAGES-1:0] stb_sync, clk_sync, dio_sync;
  logic                   clk_prev;
  logic                   stb_s, dio_s, clk_rise;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      stb_sync <= '0;
      clk_sync <= '0;
      dio_sync <= '0;
      clk_prev <= 1'b0;
    end else begin
      stb_sync <= {stb_sync[SYNC_STAGES-2:0], i_SPI_Stb};
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], i_SPI_Clk};
      dio_sync <= {dio_sync[SYNC_STAGES-2:0], i_SPI_Dio};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign stb_s    = stb_sync[SYNC_STAGES-1];
  assign dio_s    = dio_sync[SYNC_STAGES-1];
  assign clk_rise = clk_sync[SYNC_STAGES-1] & ~clk_prev;

  // Frame state machine
  state_t state_q, state_d;
  logic   start_frame, end_frame, take_bit;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) state_q <= WAIT_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    take_bit    = 1'b0;
    case (state_q)
      WAIT_IDLE: if (stb_s) state_d = IDLE;
      IDLE: begin
        if (!stb_s) begin
          state_d     = ACTIVE;
          start_frame = 1'b1;
        end
      end
      ACTIVE: begin
        // strobe release wins over a coincident clock edge
        if (stb_s) begin
          state_d   = IDLE;
          end_frame = 1'b1;
        end else if (clk_rise) begin
          take_bit = 1'b1;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  // Deserialiser; a completed byte is staged one cycle before it reaches the FIFO
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       first_flag;
  logic       push_pend;
  logic [8:0] push_data;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      bit_cnt    <= 3'd0;
      shift      <= 8'd0;
      first_flag <= 1'b0;
      push_pend  <= 1'b0;
      push_data  <= 9'd0;
    end else begin
      push_pend <= 1'b0;
      if (start_frame) begin
        bit_cnt    <= 3'd0;
        first_flag <= 1'b1;
      end
      if (take_bit) begin
        shift[bit_cnt] <= dio_s;
        bit_cnt        <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          push_pend  <= 1'b1;
          push_data  <= {first_flag, dio_s, shift[6:0]};
          first_flag <= 1'b0;
        end
      end
    end
  end

  // FWFT FIFO next-state
  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0] count, cnt_after_pop, count_nxt;
  logic          pop, push_ok, ovr_set, ferr_set;
  logic [8:0]    head_nxt;

  always_comb begin
    pop           = rx.i_Read && !rx.o_Empty;
    push_ok       = push_pend && (!rx.o_Full || pop);
    ovr_set       = push_pend && rx.o_Full && !pop;
    ferr_set      = end_frame && (bit_cnt != 3'd0);
    cnt_after_pop = count - CW'(pop);
    count_nxt     = cnt_after_pop + CW'(push_ok);
    rd_nxt        = rd_ptr + AW'(pop);
    // a push into an (effectively) empty FIFO becomes the new head directly
    head_nxt      = (push_ok && (cnt_after_pop == '0)) ? push_data : mem[rd_nxt];
  end

  always_ff @(posedge i_Clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rx.o_Empty  <= 1'b1;
      rx.o_Full   <= 1'b0;
      rx.o_Data   <= 9'd0;
    end else begin
      wr_ptr     <= wr_ptr + AW'(push_ok);
      rd_ptr     <= rd_nxt;
      count      <= count_nxt;
      rx.o_Empty <= (count_nxt == '0);
      rx.o_Full  <= (count_nxt == CW'(FIFO_DEPTH));
      if (count_nxt != '0) rx.o_Data <= head_nxt;
    end
  end

  // Sticky error flags; a new error beats a coincident clear
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      rx.o_Overrun   <= 1'b0;
      rx.o_Frame_Err <= 1'b0;
    end else begin
      if (ovr_set)            rx.o_Overrun <= 1'b1;
      else if (rx.i_Clr_Err)  rx.o_Overrun <= 1'b0;
      if (ferr_set)           rx.o_Frame_Err <= 1'b1;
      else if (rx.i_Clr_Err)  rx.o_Frame_Err <= 1'b0;
    end
  end

`ifdef SPI_RX_DIAG_EN
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Diag_State   <= 2'd0;
      o_Diag_Bit_Cnt <= 3'd0;
      o_Diag_Shift   <= 8'd0;
      o_Diag_Count   <= '0;
    end else begin
      o_Diag_State   <= state_q;
      o_Diag_Bit_Cnt <= bit_cnt;
      o_Diag_Shift   <= shift;
      o_Diag_Count   <= count;
    end
  end
`endif

endmodule

// File: tb/tb_spi_rx_fifo.sv
// Randomised self-checking bench for spi_rx_fifo against a frame-level queue model.
module tb_spi_rx_fifo;
  localparam int FIFO_DEPTH = 4;
  localparam int HALF       = 4;

  logic clk = 1'b0;
  logic rst;
  logic spi_stb, spi_clk, spi_dio;

  always #5 clk = ~clk;

  spi_rx_fifo_if rx_if ();

`ifdef SPI_RX_DIAG_EN
  logic [1:0]                   diag_state;
  logic [2:0]                   diag_bit_cnt;
  logic [7:0]                   diag_shift;
  logic [$clog2(FIFO_DEPTH):0]  diag_count;
`endif

  spi_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(2)) dut (
    .i_Clk     (clk),
    .i_Rst     (rst),
    .i_SPI_Stb (spi_stb),
    .i_SPI_Clk (spi_clk),
    .i_SPI_Dio (spi_dio),
    .rx        (rx_if.master)
`ifdef SPI_RX_DIAG_EN
    ,
    .o_Diag_State   (diag_state),
    .o_Diag_Bit_Cnt (diag_bit_cnt),
    .o_Diag_Shift   (diag_shift),
    .o_Diag_Count   (diag_count)
`endif
  );

  // Reference model: entries in arrival order plus the two sticky flags
  logic [8:0] exp_q[$];
  bit         m_ovr, m_ferr;
  logic [7:0] tx_bytes [4];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_overrun"}, 32'(rx_if.o_Overrun), 32'(m_ovr));
    chk({tag, "_frame_err"}, 32'(rx_if.o_Frame_Err), 32'(m_ferr));
  endtask

  task automatic check_reset_state();
    chk("rst_empty", 32'(rx_if.o_Empty), 32'(1));
    chk("rst_full", 32'(rx_if.o_Full), 32'(0));
    chk("rst_data", 32'(rx_if.o_Data), 32'(0));
    check_flags("rst");
  endtask

  // One SPI bit; optional read pulse timed to land on the FIFO push edge of this bit
  task automatic spi_bit(input logic b, input bit rd_pulse);
    spi_clk = 1'b0;
    spi_dio = b;
    repeat (HALF) tick();
    spi_clk = 1'b1;
    for (int j = 0; j < HALF; j++) begin
      if (rd_pulse && j == 3) begin
        chk("head_at_push", 32'(rx_if.o_Data), 32'(exp_q[0]));
        void'(exp_q.pop_front());
        rx_if.i_Read = 1'b1;
      end else begin
        rx_if.i_Read = 1'b0;
      end
      tick();
    end
    rx_if.i_Read = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b, input bit first, input bit rd_last);
    for (int i = 0; i < 7; i++) spi_bit(b[i], 1'b0);
    spi_bit(b[7], rd_last);
    if (exp_q.size() < FIFO_DEPTH) exp_q.push_back({first, b});
    else m_ovr = 1'b1;
    chk("push_latency_empty", 32'(rx_if.o_Empty), 32'(0));
    chk("full_after_push", 32'(rx_if.o_Full), 32'(exp_q.size() == FIFO_DEPTH));
  endtask

  task automatic spi_frame(input int nbytes, input int partial, input bit rd_last);
    spi_stb = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < nbytes; i++)
      spi_byte(tx_bytes[i], (i == 0), rd_last && (i == nbytes - 1));
    for (int i = 0; i < partial; i++) spi_bit(1'($urandom_range(0, 1)), 1'b0);
    repeat (3) tick();
    spi_stb = 1'b1;
    repeat (6) tick();
    if (partial != 0) m_ferr = 1'b1;
    check_flags("frame");
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      chk("rd_not_empty", 32'(rx_if.o_Empty), 32'(0));
      chk("rd_data", 32'(rx_if.o_Data), 32'(exp_q[0]));
      rx_if.i_Read = 1'b1;
      tick();
      rx_if.i_Read = 1'b0;
      void'(exp_q.pop_front());
    end
    chk("empty_state", 32'(rx_if.o_Empty), 32'(exp_q.size() == 0));
  endtask

  task automatic clr_err();
    rx_if.i_Clr_Err = 1'b1;
    tick();
    rx_if.i_Clr_Err = 1'b0;
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    check_flags("clr");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; spi_stb = 1'b1; spi_clk = 1'b1; spi_dio = 1'b0;
    rx_if.i_Read = 1'b0; rx_if.i_Clr_Err = 1'b0;
    m_ovr = 1'b0; m_ferr = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_state();
    repeat (5) tick();

    // single byte, latency and tag
    tx_bytes[0] = 8'h44;
    spi_frame(1, 0, 1'b0);
    drain(1);

    // multi-byte frame, only the first is tagged
    tx_bytes[0] = 8'hC0; tx_bytes[1] = 8'h3F; tx_bytes[2] = 8'h06;
    spi_frame(3, 0, 1'b0);
    drain(3);

    // partial byte then recovery
    spi_frame(0, 5, 1'b0);
    tx_bytes[0] = 8'hA5;
    spi_frame(1, 0, 1'b0);
    drain(1);
    clr_err();

    // overflow without reads
    for (int i = 1; i <= 5; i++) begin
      tx_bytes[0] = 8'(i);
      spi_frame(1, 0, 1'b0);
    end
    drain(4);
    clr_err();

    // push into full FIFO with a coincident pop
    for (int i = 1; i <= 5; i++) begin
      tx_bytes[0] = 8'(i);
      spi_frame(1, 0, (i == 5));
    end
    drain(4);

    // reset in mid-byte with strobe low
    spi_stb = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 3; i++) spi_bit(1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    m_ovr = 1'b0; m_ferr = 1'b0;
    check_reset_state();
    for (int i = 0; i < 8; i++) spi_bit(1'($urandom_range(0, 1)), 1'b0);
    repeat (3) tick();
    spi_stb = 1'b1;
    repeat (8) tick();
    chk("post_rst_empty", 32'(rx_if.o_Empty), 32'(1));
    check_flags("post_rst");
    tx_bytes[0] = 8'h5A;
    spi_frame(1, 0, 1'b0);
    drain(1);

    // read while empty, and SPI clocks with strobe high
    rx_if.i_Read = 1'b1;
    tick();
    rx_if.i_Read = 1'b0;
    chk("rd_empty_empty", 32'(rx_if.o_Empty), 32'(1));
    chk("rd_empty_full", 32'(rx_if.o_Full), 32'(0));
    for (int i = 0; i < 4; i++) begin
      spi_clk = 1'b0; repeat (HALF) tick();
      spi_clk = 1'b1; repeat (HALF) tick();
    end
    chk("stb_high_clk_empty", 32'(rx_if.o_Empty), 32'(1));
    tx_bytes[0] = 8'h77; tx_bytes[1] = 8'h88;
    spi_frame(2, 0, 1'b0);
    drain(2);

    // randomised frames, partial reads, occasional clears
    for (int it = 0; it < 40; it++) begin
      int nb, np, nr;
      nb = $urandom_range(0, 3);
      np = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      for (int i = 0; i < 4; i++) tx_bytes[i] = 8'($urandom);
      spi_frame(nb, np, 1'b0);
      nr = $urandom_range(0, exp_q.size());
      drain(nr);
      if ($urandom_range(0, 3) == 0) clr_err();
    end
    drain(exp_q.size());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
